// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    HOLD    = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, sync write, registered read.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_comb begin
    rd_data_d = mem[i_raddr];
  end

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign o_rdata = rd_data_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Sequences UART RX bytes into SOF/length/payload frames with inter-byte timeout.
// Define UART_FRAME_CHECKSUM_EN to require and verify a trailing checksum byte.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 8680,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
  localparam int        AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_rx_valid,
  input  logic [7:0]    i_rx_byte,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_frame_valid,
  output logic [7:0]    o_frame_len,
  input  logic          i_frame_ack,
  output logic          o_err_pulse,
  output logic [1:0]    o_err_code,
  output logic          o_drop_pulse
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_pulse_q, err_pulse_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          drop_pulse_q, drop_pulse_d;
  logic          in_frame, tmo_hit, len_bad, last_byte, buf_we;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]    acc_q, acc_d, csum_sum;
  logic          csum_ok;
`endif

  assign in_frame  = state_q inside {LEN, PAYLOAD, CSUM};
  // A byte in the expiry cycle wins over the timeout.
  assign tmo_hit   = in_frame && !i_rx_valid && (tmo_q == TW'(TIMEOUT_CLKS - 1));
  assign len_bad   = (i_rx_byte == 8'd0) || (i_rx_byte > 8'(MAX_LEN));
  assign last_byte = (idx_q + 8'd1) == len_q;
  assign buf_we    = (state_q == PAYLOAD) && i_rx_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (i_rx_valid && i_rx_byte == SOF_BYTE) state_d = LEN;
      LEN:     if (i_rx_valid) state_d = len_bad ? HUNT : PAYLOAD;
               else if (tmo_hit) state_d = HUNT;
      PAYLOAD: if (i_rx_valid) begin
                 if (last_byte) begin
`ifdef UART_FRAME_CHECKSUM_EN
                   state_d = CSUM;
`else
                   state_d = HOLD;
`endif
                 end
               end else if (tmo_hit) state_d = HUNT;
`ifdef UART_FRAME_CHECKSUM_EN
      CSUM:    if (i_rx_valid) state_d = csum_ok ? HOLD : HUNT;
               else if (tmo_hit) state_d = HUNT;
`endif
      HOLD:    if (i_frame_ack) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    o_frame_valid = (state_q == HOLD);
  end

  always_comb begin
    len_d        = len_q;
    idx_d        = idx_q;
    tmo_d        = '0;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    drop_pulse_d = (state_q == HOLD) && i_rx_valid;
    if (in_frame && !i_rx_valid && !tmo_hit) tmo_d = tmo_q + 1'b1;
    if (tmo_hit) begin
      err_pulse_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end
    if (i_rx_valid) begin
      case (state_q)
        LEN: if (len_bad) begin
               err_pulse_d = 1'b1;
               err_code_d  = ERR_LEN;
             end else begin
               len_d = i_rx_byte;
               idx_d = '0;
             end
        PAYLOAD: idx_d = idx_q + 8'd1;
`ifdef UART_FRAME_CHECKSUM_EN
        CSUM: if (!csum_ok) begin
                err_pulse_d = 1'b1;
                err_code_d  = ERR_CSUM;
              end
`endif
        default: ;
      endcase
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  // Running sum covers the length byte and every payload byte.
  assign csum_sum = acc_q + i_rx_byte;
  assign csum_ok  = (csum_sum == 8'd0);

  always_comb begin
    acc_d = acc_q;
    if (i_rx_valid && state_q == LEN)          acc_d = i_rx_byte;
    else if (i_rx_valid && state_q == PAYLOAD) acc_d = csum_sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      drop_pulse_q <= 1'b0;
    end else begin
      len_q        <= len_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_we    (buf_we),
    .i_waddr (idx_q[AW-1:0]),
    .i_wdata (i_rx_byte),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );

  assign o_frame_len  = len_q;
  assign o_err_pulse  = err_pulse_q;
  assign o_err_code   = err_code_q;
  assign o_drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: vector table plus timeout/reset sequences.
module tb_uart_rx_frame_ctrl;

  localparam int TMO = 8680;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_rx_valid;
  logic [7:0] i_rx_byte;
  logic [3:0] i_rd_addr;
  logic [7:0] o_rd_data;
  logic       o_frame_valid;
  logic [7:0] o_frame_len;
  logic       i_frame_ack;
  logic       o_err_pulse;
  logic [1:0] o_err_code;
  logic       o_drop_pulse;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .i_rx_valid    (i_rx_valid),
    .i_rx_byte     (i_rx_byte),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_frame_valid (o_frame_valid),
    .o_frame_len   (o_frame_len),
    .i_frame_ack   (i_frame_ack),
    .o_err_pulse   (o_err_pulse),
    .o_err_code    (o_err_code),
    .o_drop_pulse  (o_drop_pulse)
  );

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       ack;
    logic [3:0] a;
    logic       chk_rd;
    logic [7:0] rd;
    logic       fv;
    logic [7:0] len;
    logic       ep;
    logic [1:0] ec;
    logic       dp;
  } vec_t;

  vec_t tbl[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // Byte step: expected outputs one clock after the strobe.
  task automatic pb(input logic [7:0] b, input logic fv, input logic [7:0] len,
                    input logic ep, input logic [1:0] ec,
                    input logic dp = 1'b0, input logic ack = 1'b0);
    vec_t t;
    t.v = 1'b1; t.b = b; t.ack = ack; t.a = '0; t.chk_rd = 1'b0; t.rd = '0;
    t.fv = fv; t.len = len; t.ep = ep; t.ec = ec; t.dp = dp;
    tbl.push_back(t);
  endtask

  // Read step: payload byte expected one clock after the address.
  task automatic pr(input logic [3:0] a, input logic [7:0] rd, input logic [7:0] len,
                    input logic [1:0] ec);
    vec_t t;
    t.v = 1'b0; t.b = '0; t.ack = 1'b0; t.a = a; t.chk_rd = 1'b1; t.rd = rd;
    t.fv = 1'b1; t.len = len; t.ep = 1'b0; t.ec = ec; t.dp = 1'b0;
    tbl.push_back(t);
  endtask

  // Idle step, optionally with ack.
  task automatic pi(input logic ack, input logic fv, input logic [7:0] len, input logic [1:0] ec);
    vec_t t;
    t.v = 1'b0; t.b = '0; t.ack = ack; t.a = '0; t.chk_rd = 1'b0; t.rd = '0;
    t.fv = fv; t.len = len; t.ep = 1'b0; t.ec = ec; t.dp = 1'b0;
    tbl.push_back(t);
  endtask

  task automatic sendb(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_byte  = b;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] acc8;
    logic [1:0] e;

    reset = 1'b1; i_rx_valid = 1'b0; i_rx_byte = '0; i_rd_addr = '0; i_frame_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fv", o_frame_valid, 1'b0);
    chk("rst_len", o_frame_len, 8'd0);
    chk("rst_rd", o_rd_data, 8'd0);
    chk("rst_ep", o_err_pulse, 1'b0);
    chk("rst_ec", o_err_code, 2'd0);
    chk("rst_dp", o_drop_pulse, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Basic frame; 0x97 brings 03+11+22+33 to zero mod 256.
    pb(8'hA5, 0, 0, 0, 0); pb(8'h03, 0, 0, 0, 0); pb(8'h11, 0, 0, 0, 0); pb(8'h22, 0, 0, 0, 0);
    if (CS) begin pb(8'h33, 0, 0, 0, 0); pb(8'h97, 1, 3, 0, 0); end
    else    pb(8'h33, 1, 3, 0, 0);
    pr(0, 8'h11, 3, 0); pr(1, 8'h22, 3, 0); pr(2, 8'h33, 3, 0);
    pb(8'h55, 1, 3, 0, 0, 1); pb(8'h66, 1, 3, 0, 0, 1); pb(8'h77, 1, 3, 0, 0, 1);
    pr(0, 8'h11, 3, 0); pr(1, 8'h22, 3, 0); pr(2, 8'h33, 3, 0);
    // SOF arriving with the ack is dropped, so the following 00 is not a length.
    pb(8'hA5, 0, 0, 0, 0, 1, 1);
    pb(8'h00, 0, 0, 0, 0);
    pi(1, 0, 0, 0);

    // Bad lengths: zero and MAX_LEN+1.
    pb(8'hA5, 0, 0, 0, 0); pb(8'h00, 0, 0, 1, 1); pi(0, 0, 0, 1);
    pb(8'hA5, 0, 0, 0, 1); pb(8'h11, 0, 0, 1, 1); pi(0, 0, 0, 1);

    // Length exactly MAX_LEN.
    pb(8'hA5, 0, 0, 0, 1); pb(8'h10, 0, 0, 0, 1);
    acc8 = 8'h10;
    for (int k = 1; k <= 16; k++) begin
      acc8 = acc8 + 8'(k);
      pb(8'(k), (!CS && k == 16), 8'd16, 0, 1);
    end
    if (CS) pb(8'h00 - acc8, 1, 16, 0, 1);
    pr(15, 8'h10, 16, 1); pr(0, 8'h01, 16, 1);
    pi(1, 0, 0, 1); pi(0, 0, 0, 1);

    // SOF value inside a frame is ordinary data.
    pb(8'hA5, 0, 0, 0, 1); pb(8'h02, 0, 0, 0, 1); pb(8'hA5, 0, 0, 0, 1);
    if (CS) begin pb(8'hA5, 0, 0, 0, 1); pb(8'hB4, 1, 2, 0, 1); end
    else    pb(8'hA5, 1, 2, 0, 1);
    pr(0, 8'hA5, 2, 1); pr(1, 8'hA5, 2, 1);
    pi(1, 0, 0, 1);

    // Checksum failure (or, without checksum, a normal frame plus a drop).
    pb(8'hA5, 0, 0, 0, 1); pb(8'h02, 0, 0, 0, 1); pb(8'h10, 0, 0, 0, 1);
    if (CS) begin
      pb(8'h20, 0, 0, 0, 1); pb(8'h55, 0, 0, 1, 3); pi(0, 0, 0, 3);
      e = 2'd3;
    end else begin
      pb(8'h20, 1, 2, 0, 1); pb(8'h55, 1, 2, 0, 1, 1); pi(1, 0, 0, 1);
      e = 2'd1;
    end
    pi(0, 0, 0, e);

    for (int i = 0; i < tbl.size(); i++) begin
      i_rx_valid = tbl[i].v; i_rx_byte = tbl[i].b; i_frame_ack = tbl[i].ack; i_rd_addr = tbl[i].a;
      @(negedge clk);
      chk($sformatf("v%0d_fv", i), o_frame_valid, tbl[i].fv);
      if (tbl[i].fv) chk($sformatf("v%0d_len", i), o_frame_len, tbl[i].len);
      chk($sformatf("v%0d_ep", i), o_err_pulse, tbl[i].ep);
      chk($sformatf("v%0d_ec", i), o_err_code, tbl[i].ec);
      chk($sformatf("v%0d_dp", i), o_drop_pulse, tbl[i].dp);
      if (tbl[i].chk_rd) chk($sformatf("v%0d_rd", i), o_rd_data, tbl[i].rd);
    end
    i_rx_valid = 1'b0; i_frame_ack = 1'b0; i_rd_addr = '0;

    // Timeout: error visible TIMEOUT_CLKS clocks after the last accepted byte.
    sendb(8'hA5); sendb(8'h02); sendb(8'h10);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_early", o_err_pulse, 1'b0);
    @(negedge clk);
    chk("tmo_ep", o_err_pulse, 1'b1);
    chk("tmo_ec", o_err_code, 2'd2);
    @(negedge clk);
    chk("tmo_ep_off", o_err_pulse, 1'b0);
    chk("tmo_fv", o_frame_valid, 1'b0);

    // Byte in the expiry cycle beats the timeout.
    sendb(8'hA5); sendb(8'h02); sendb(8'h10);
    repeat (TMO - 1) @(negedge clk);
    sendb(8'h20);
    chk("exp_ep", o_err_pulse, 1'b0);
    if (CS) sendb(8'hCE);
    chk("exp_fv", o_frame_valid, 1'b1);
    chk("exp_len", o_frame_len, 8'd2);
    i_frame_ack = 1'b1;
    @(negedge clk);
    i_frame_ack = 1'b0;
    chk("exp_ack", o_frame_valid, 1'b0);

    // Reset in the middle of the payload.
    sendb(8'hA5); sendb(8'h03); sendb(8'h11);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_fv", o_frame_valid, 1'b0);
    chk("mid_len", o_frame_len, 8'd0);
    chk("mid_ep", o_err_pulse, 1'b0);
    chk("mid_ec", o_err_code, 2'd0);
    chk("mid_dp", o_drop_pulse, 1'b0);
    chk("mid_rd", o_rd_data, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    sendb(8'hA5); sendb(8'h01); sendb(8'h7E);
    if (CS) sendb(8'h81);
    chk("post_fv", o_frame_valid, 1'b1);
    chk("post_len", o_frame_len, 8'd1);
    chk("post_ec", o_err_code, 2'd0);
    i_rd_addr = '0;
    @(negedge clk);
    chk("post_rd", o_rd_data, 8'h7E);
    i_frame_ack = 1'b1;
    @(negedge clk);
    i_frame_ack = 1'b0;
    chk("post_ack", o_frame_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
